if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC, selects the next PC (sequential, branch, jump, jump-register) and drives the instruction-memory address.
- Latches the fetched instruction into the IF/ID register, which the ID stage consumes.
- Directly consumes IRFlush from the flush unit, and PCWrite/IRWrite from the hazard unit. Keeps a saturating count of flushed fetch slots for performance debug.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
CNT_W, 16, width of the flushed-slot counter

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
PCWrite  input  1  1 = PC may update this cycle; 0 = hold PC (stall)
IRWrite  input  1  1 = IF/ID register may load; 0 = hold (stall)
IRFlush  input  1  1 = squash the IF/ID register (taken branch/jump)
pc_src  input  2  next-PC select: 00 PC+4, 01 branch_target, 10 jump_target, 11 jr_target
branch_target  input  32  branch target address computed in ID
jump_target  input  32  J/JAL target address
jr_target  input  32  JR register value
imem_addr  output  32  instruction-memory address, equals PC (combinational read)
imem_rdata  input  32  instruction word returned for imem_addr, same cycle
if_id_instr  output  32  IF/ID instruction register
if_id_pc4  output  32  IF/ID copy of fetch PC+4
if_id_valid  output  1  1 = IF/ID holds a live instruction, 0 = bubble
flush_count  output  CNT_W  saturating count of flushed fetch slots

Behaviour:
- Reset (rst_n low, asynchronous, any time): PC=PC_RESET, if_id_instr=32'h0 (NOP), if_id_pc4=0, if_id_valid=0, flush_count=0.
  - Deassertion takes effect at the next rising edge: the first fetch is from PC_RESET.
  - Reset asserted mid-stall or mid-flush discards everything; no pending state survives.
- PC+4 is 32-bit wrap-around: 32'hFFFF_FFFC + 4 = 0.
- imem_addr = PC, combinational. The memory answers within the same cycle; fetch latency is 1 cycle (instruction at PC appears on if_id_instr after the edge).
- Next-PC mux by pc_src. Bits [1:0] of any selected target are forced to 00 on load, so the PC is always word-aligned.
- PC register: if PCWrite=1, PC <= next-PC; else PC holds. pc_src is honoured only when PCWrite=1.
- IF/ID register, evaluated at each edge in priority order:
  1. IRFlush=1: if_id_instr <= 0, if_id_valid <= 0, if_id_pc4 <= PC+4. Flush wins over IRWrite=0.
  2. IRWrite=0: all IF/ID fields hold.
  3. Otherwise: if_id_instr <= imem_rdata, if_id_pc4 <= PC+4, if_id_valid <= 1.
- Simultaneous IRFlush=1 and PCWrite=1 with pc_src≠00 (normal taken branch): PC loads the target and the wrong-path fetch is squashed in the same edge. The next cycle fetches the target.
- IRFlush=1 with PCWrite=0: IF/ID becomes a bubble and the PC holds. Legal; the hazard unit must not rely on holding the squashed instruction.
- flush_count: +1 on every edge with IRFlush=1 (whether or not IF/ID was valid). Saturates at all ones and never wraps. Only reset clears it.
- All outputs are registered except imem_addr. There are no combinational paths from inputs to if_id_* or flush_count.

Test Plan:
- Reset/sequential: rst_n low 3 cycles, release, PCWrite=IRWrite=1, pc_src=00, imem_rdata=addr^32'hA5A5_0000 -> imem_addr 0,4,8,C on successive cycles; after edge 1 if_id_instr=32'hA5A5_0000, if_id_pc4=4, valid=1.
- Stall: at PC=8 hold PCWrite=IRWrite=0 for 2 cycles -> imem_addr stays 8, if_id_instr/pc4 (pc4=8) unchanged, valid stays 1; resume -> PC=C next.
- Taken branch: at PC=10, IRFlush=1, pc_src=01, branch_target=32'h0000_0103 -> next imem_addr=0x100, if_id_instr=0, valid=0, flush_count=1; following edge latches the instruction at 0x100 with pc4=0x104.
- Flush vs stall: IRFlush=1, IRWrite=0, PCWrite=0 -> PC holds, IF/ID becomes bubble, flush_count increments; separately, pc_src=11 with PCWrite=0 -> PC unchanged.
- Wrap/saturation: PC=FFFF_FFFC sequential -> next PC=0, pc4=0. CNT_W=4 with IRFlush held 20 cycles -> flush_count stops at 4'hF.
- Async reset mid-operation: assert rst_n low between edges during a flush burst -> all outputs return to reset values immediately without waiting for clk.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Instruction-memory bus between the fetch stage and imem.
// Read is combinational: rdata answers addr in the same cycle.
interface if_id_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   modport master (
      output imem_addr,
      input  imem_rdata
   );

   modport slave (
      input  imem_addr,
      output imem_rdata
   );
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage: PC, next-PC select, IF/ID register
// and a saturating count of flushed fetch slots.
module if_id_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               PCWrite,
   input  logic               IRWrite,
   input  logic               IRFlush,
   input  logic [1:0]         pc_src,
   input  logic [31:0]        branch_target,
   input  logic [31:0]        jump_target,
   input  logic [31:0]        jr_target,
   if_id_stage_if.master      imem,
   output logic [31:0]        if_id_instr,
   output logic [31:0]        if_id_pc4,
   output logic               if_id_valid,
   output logic [CNT_W-1:0]   flush_count
);

   localparam logic [1:0] SEL_SEQ = 2'b00;
   localparam logic [1:0] SEL_BR  = 2'b01;
   localparam logic [1:0] SEL_J   = 2'b10;
   localparam logic [1:0] SEL_JR  = 2'b11;

   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] tgt;
   logic [31:0] next_pc;

   assign imem.imem_addr = pc;
   assign pc4 = pc + 32'd4;

   always_comb begin
      tgt = pc4;
      unique case (pc_src)
         SEL_SEQ: tgt = pc4;
         SEL_BR:  tgt = branch_target;
         SEL_J:   tgt = jump_target;
         SEL_JR:  tgt = jr_target;
      endcase
   end

   // low bits cleared so the PC stays word-aligned
   assign next_pc = {tgt[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= PC_RESET;
      end else if (PCWrite) begin
         pc <= next_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_instr <= 32'h0;
         if_id_pc4   <= 32'h0;
         if_id_valid <= 1'b0;
      end else if (IRFlush) begin
         if_id_instr <= 32'h0;
         if_id_pc4   <= pc4;
         if_id_valid <= 1'b0;
      end else if (IRWrite) begin
         if_id_instr <= imem.imem_rdata;
         if_id_pc4   <= pc4;
         if_id_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_count <= '0;
      end else if (IRFlush && (flush_count != '1)) begin
         flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: fetch, stall, flush,
// wrap-around, counter saturation and async reset.
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        PCWrite;
   logic        IRWrite;
   logic        IRFlush;
   logic [1:0]  pc_src;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] jr_target;

   logic [31:0] instr;
   logic [31:0] pc4;
   logic        valid;
   logic [15:0] fcnt;

   logic [31:0] instr_b;
   logic [31:0] pc4_b;
   logic        valid_b;
   logic [3:0]  fcnt_b;

   int errs = 0;
   int checks = 0;

   if_id_stage_if ifc ();
   if_id_stage_if ifc_b ();

   assign ifc.imem_rdata   = ifc.imem_addr ^ 32'hA5A5_0000;
   assign ifc_b.imem_rdata = ifc_b.imem_addr ^ 32'hA5A5_0000;

   always #5 clk = ~clk;

   if_id_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .PCWrite       (PCWrite),
      .IRWrite       (IRWrite),
      .IRFlush       (IRFlush),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .jr_target     (jr_target),
      .imem          (ifc.master),
      .if_id_instr   (instr),
      .if_id_pc4     (pc4),
      .if_id_valid   (valid),
      .flush_count   (fcnt)
   );

   if_id_stage #(.CNT_W(4)) dut_b (
      .clk           (clk),
      .rst_n         (rst_n),
      .PCWrite       (PCWrite),
      .IRWrite       (IRWrite),
      .IRFlush       (IRFlush),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .jr_target     (jr_target),
      .imem          (ifc_b.master),
      .if_id_instr   (instr_b),
      .if_id_pc4     (pc4_b),
      .if_id_valid   (valid_b),
      .flush_count   (fcnt_b)
   );

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_if(
      input string       tag,
      input logic [31:0] a,
      input logic [31:0] i,
      input logic [31:0] p,
      input logic        v
   );
      check({tag, ".addr"}, ifc.imem_addr, a);
      check({tag, ".instr"}, instr, i);
      check({tag, ".pc4"}, pc4, p);
      check({tag, ".valid"}, 32'(valid), 32'(v));
   endtask

   initial begin
      rst_n = 1'b0;
      PCWrite = 1'b1;
      IRWrite = 1'b1;
      IRFlush = 1'b0;
      pc_src = 2'b00;
      branch_target = 32'h0;
      jump_target = 32'h0;
      jr_target = 32'h0;

      repeat (3) step();
      chk_if("rst", 32'h0, 32'h0, 32'h0, 1'b0);
      check("rst.fcnt", 32'(fcnt), 32'h0);
      rst_n = 1'b1;
      check("first_addr", ifc.imem_addr, 32'h0);

      step();
      chk_if("seq1", 32'h4, 32'hA5A5_0000, 32'h4, 1'b1);
      step();
      chk_if("seq2", 32'h8, 32'hA5A5_0004, 32'h8, 1'b1);

      PCWrite = 1'b0;
      IRWrite = 1'b0;
      step();
      chk_if("stall1", 32'h8, 32'hA5A5_0004, 32'h8, 1'b1);
      step();
      chk_if("stall2", 32'h8, 32'hA5A5_0004, 32'h8, 1'b1);

      PCWrite = 1'b1;
      IRWrite = 1'b1;
      step();
      chk_if("resume", 32'hC, 32'hA5A5_0008, 32'hC, 1'b1);
      step();
      chk_if("seq3", 32'h10, 32'hA5A5_000C, 32'h10, 1'b1);

      IRFlush = 1'b1;
      pc_src = 2'b01;
      branch_target = 32'h0000_0103;
      step();
      chk_if("br", 32'h100, 32'h0, 32'h14, 1'b0);
      check("br.fcnt", 32'(fcnt), 32'h1);

      IRFlush = 1'b0;
      pc_src = 2'b00;
      step();
      chk_if("br_tgt", 32'h104, 32'hA5A5_0100, 32'h104, 1'b1);

      IRFlush = 1'b1;
      IRWrite = 1'b0;
      PCWrite = 1'b0;
      step();
      chk_if("fl_stall", 32'h104, 32'h0, 32'h108, 1'b0);
      check("fl_stall.fcnt", 32'(fcnt), 32'h2);

      IRFlush = 1'b0;
      IRWrite = 1'b1;
      pc_src = 2'b11;
      jr_target = 32'h0000_2000;
      step();
      chk_if("jr_hold", 32'h104, 32'hA5A5_0104, 32'h108, 1'b1);
      check("jr_hold.fcnt", 32'(fcnt), 32'h2);

      PCWrite = 1'b1;
      IRFlush = 1'b1;
      pc_src = 2'b10;
      jump_target = 32'hFFFF_FFFE;
      step();
      chk_if("jmp", 32'hFFFF_FFFC, 32'h0, 32'h108, 1'b0);

      IRFlush = 1'b0;
      pc_src = 2'b00;
      step();
      chk_if("wrap", 32'h0, 32'h5A5A_FFFC, 32'h0, 1'b1);

      pc_src = 2'b11;
      jr_target = 32'h0000_2001;
      step();
      check("jr.addr", ifc.imem_addr, 32'h2000);
      check("jr.fcnt", 32'(fcnt), 32'h3);

      pc_src = 2'b00;
      IRFlush = 1'b1;
      repeat (20) step();
      check("sat16", 32'(fcnt), 32'd23);
      check("sat4", 32'(fcnt_b), 32'hF);
      check("sat.valid", 32'(valid), 32'h0);

      #2;
      rst_n = 1'b0;
      #1;
      chk_if("arst", 32'h0, 32'h0, 32'h0, 1'b0);
      check("arst.fcnt", 32'(fcnt), 32'h0);
      check("arst.fcnt_b", 32'(fcnt_b), 32'h0);
      check("arst.addr_b", ifc_b.imem_addr, 32'h0);

      step();
      IRFlush = 1'b0;
      rst_n = 1'b1;
      step();
      chk_if("post_rst", 32'h4, 32'hA5A5_0000, 32'h4, 1'b1);
      check("post_rst.fcnt", 32'(fcnt), 32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
